// File: rtl/lif_scheduler.sv
// lif_scheduler: sweeps one shared leaky integrate-and-fire update across
// NUM_NEURONS virtual neurons, one sweep per accepted start pulse.
//
// Ports
//   clk, reset_n         clock (rising edge) and asynchronous active-low reset
//   start                begin a timestep sweep (sampled only while idle)
//   cfg_we/cfg_threshold threshold write (honoured only while idle)
//   cur_req/cur_idx      request input current for neuron cur_idx
//   cur_valid/current_in current for cur_idx; transfer on cur_req && cur_valid
//   spike_valid/spike_idx/spike_ready  spike event out, valid/ready handshake
//   busy                 high whenever a sweep is in progress
//   done                 one-cycle pulse at the end of each sweep
//   step_count           number of completed sweeps (wraps at 2^16)
module lif_scheduler #(
    parameter int NUM_NEURONS = 8,
    parameter int WIDTH       = 8,
    parameter int IDX_W       = 3,
    parameter int LEAK_SHIFT  = 1,
    parameter int REFRACT     = 2,
    parameter int THRESH_RST  = 200
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_threshold,
    output logic             cur_req,
    output logic [IDX_W-1:0] cur_idx,
    input  logic             cur_valid,
    input  logic [WIDTH-1:0] current_in,
    output logic             spike_valid,
    output logic [IDX_W-1:0] spike_idx,
    input  logic             spike_ready,
    output logic             busy,
    output logic             done,
    output logic [15:0]      step_count
);

    // Refractory counter must hold REFRACT; keep at least one bit when REFRACT is 0/1.
    localparam int RW = (REFRACT < 2) ? 1 : $clog2(REFRACT + 1);

    typedef enum logic [2:0] {IDLE, FETCH, UPDATE, EMIT, DONE} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] threshold;
    logic [WIDTH-1:0] cur_p0;
    logic [WIDTH-1:0] mem  [NUM_NEURONS];
    logic [RW-1:0]    refr [NUM_NEURONS];

    logic             last;
    logic             in_refr;
    logic [WIDTH-1:0] n_upd;
    logic             fire;

    // Unsigned add clamped to all-ones on carry out.
    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
    endfunction

    assign last    = (idx == IDX_W'(NUM_NEURONS - 1));
    assign in_refr = (refr[idx] != '0);
    assign n_upd   = sat_add(cur_p0, mem[idx] >> LEAK_SHIFT);
    // A refractory neuron never fires regardless of the computed value.
    assign fire    = !in_refr && (n_upd >= threshold);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cur_req     = 1'b0;
        spike_valid = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = FETCH;
            end
            FETCH: begin
                cur_req = 1'b1;
                if (cur_valid) state_nxt = UPDATE;
            end
            UPDATE: begin
                if (fire)      state_nxt = EMIT;
                else if (last) state_nxt = DONE;
                else           state_nxt = FETCH;
            end
            EMIT: begin
                spike_valid = 1'b1;
                if (spike_ready) state_nxt = last ? DONE : FETCH;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign cur_idx   = idx;
    assign spike_idx = idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx        <= '0;
            threshold  <= WIDTH'(THRESH_RST);
            cur_p0     <= '0;
            step_count <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                mem[i]  <= '0;
                refr[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    // Write and start together: the new threshold governs this sweep.
                    if (cfg_we) threshold <= cfg_threshold;
                    if (start)  idx <= '0;
                end
                FETCH: begin
                    if (cur_valid) cur_p0 <= current_in;
                end
                UPDATE: begin
                    if (in_refr) begin
                        refr[idx] <= refr[idx] - RW'(1);
                        mem[idx]  <= '0;
                    end else if (fire) begin
                        mem[idx]  <= '0;
                        refr[idx] <= RW'(REFRACT);
                    end else begin
                        mem[idx]  <= n_upd;
                    end
                    if (!fire && !last) idx <= idx + IDX_W'(1);
                end
                EMIT: begin
                    if (spike_ready && !last) idx <= idx + IDX_W'(1);
                end
                DONE: begin
                    step_count <= step_count + 16'd1;
                    idx        <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lif_scheduler.sv
module tb_lif_scheduler;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         cfg_we = 1'b0;
    logic [W-1:0] cfg_threshold = '0;
    logic         cur_req;
    logic [1:0]   cur_idx;
    logic         cur_valid = 1'b1;
    logic [W-1:0] current_in = '0;
    logic         spike_valid;
    logic [1:0]   spike_idx;
    logic         spike_ready = 1'b1;
    logic         busy;
    logic         done;
    logic [15:0]  step_count;

    always #5 clk = ~clk;

    lif_scheduler #(
        .NUM_NEURONS(N), .WIDTH(W), .IDX_W(2),
        .LEAK_SHIFT(1), .REFRACT(2), .THRESH_RST(200)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cfg_we(cfg_we),
        .cfg_threshold(cfg_threshold), .cur_req(cur_req), .cur_idx(cur_idx),
        .cur_valid(cur_valid), .current_in(current_in),
        .spike_valid(spike_valid), .spike_idx(spike_idx),
        .spike_ready(spike_ready), .busy(busy), .done(done),
        .step_count(step_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model of the neuron array
    int m_st [N];
    int m_rf [N];
    int m_thr;
    int m_steps;
    int exp_q [$];
    logic [W-1:0] cur_tab [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0;
            m_rf[i] = 0;
        end
        m_thr   = 200;
        m_steps = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        start   = 1'b0;
        cfg_we  = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_cur_req", cur_req, 0);
        chk("rst_done", done, 0);
        chk("rst_spike_valid", spike_valid, 0);
        chk("rst_step_count", step_count, 0);
        for (int i = 0; i < N; i++) chk("rst_mem", dut.mem[i], 0);
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One sweep: model pushes expected spikes, DUT spikes pop and compare.
    task automatic sweep(input int rdly, input int vdly, input bit busy_pokes,
                         input bit wr, input int wr_val);
        int exp_cyc, nsp, fetch_i, rcnt, vcnt, n;
        bit fin;
        logic [1:0] hold_idx;
        @(negedge clk);
        if (wr) begin
            cfg_we        = 1'b1;
            cfg_threshold = W'(wr_val);
            m_thr         = wr_val;
        end
        start = 1'b1;
        nsp = 0;
        for (int i = 0; i < N; i++) begin
            if (m_rf[i] > 0) begin
                m_rf[i]--;
                m_st[i] = 0;
            end else begin
                n = int'(cur_tab[i]) + (m_st[i] >> 1);
                if (n > 255) n = 255;
                if (n >= m_thr) begin
                    m_st[i] = 0;
                    m_rf[i] = 2;
                    exp_q.push_back(i);
                    nsp++;
                end else begin
                    m_st[i] = n;
                end
            end
        end
        exp_cyc = 2 * N + 1 + nsp * (1 + rdly) + vdly;
        @(negedge clk);
        start  = 1'b0;
        cfg_we = 1'b0;
        fetch_i = 0; rcnt = 0; vcnt = 0; fin = 0; hold_idx = '0;
        for (int cyc = 1; cyc <= 200 && !fin; cyc++) begin
            // Config write and start while busy must both be ignored.
            cfg_we = 1'b0;
            start  = 1'b0;
            if (busy_pokes && cyc == 3) begin
                cfg_we        = 1'b1;
                cfg_threshold = 8'd10;
            end
            if (busy_pokes && cyc == 4) start = 1'b1;
            if (cur_req) begin
                chk("fetch_idx", cur_idx, fetch_i);
                current_in = cur_tab[cur_idx];
                if (fetch_i == 0 && vcnt < vdly) begin
                    cur_valid = 1'b0;
                    vcnt++;
                end else begin
                    cur_valid = 1'b1;
                    fetch_i++;
                end
            end
            if (spike_valid) begin
                if (rcnt < rdly) begin
                    if (rcnt == 0) hold_idx = spike_idx;
                    else chk("spike_hold", spike_idx, hold_idx);
                    chk("no_req_in_emit", cur_req, 0);
                    spike_ready = 1'b0;
                    rcnt++;
                end else begin
                    chk("spike_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) chk("spike_idx", spike_idx, exp_q.pop_front());
                    spike_ready = 1'b1;
                    rcnt = 0;
                end
            end
            if (done) begin
                chk("done_cycle", cyc, exp_cyc);
                chk("spikes_all_seen", exp_q.size(), 0);
                fin = 1;
            end
            if (!fin) @(negedge clk);
        end
        cfg_we = 1'b0;
        start  = 1'b0;
        if (!fin) chk("sweep_timeout", fin, 1);
        m_steps++;
        @(negedge clk);
        chk("step_count", step_count, m_steps);
        chk("idle_busy", busy, 0);
        for (int i = 0; i < N; i++) chk("state", dut.mem[i], m_st[i]);
        exp_q.delete();
    endtask

    initial begin
        bit hit;
        model_clear();

        // Uniform small currents: no spikes, states settle at 10 then 15.
        do_reset();
        cur_tab = '{8'd10, 8'd10, 8'd10, 8'd10};
        sweep(0, 0, 0, 0, 0);
        sweep(0, 3, 0, 0, 0);

        // Integration to threshold on neuron 2, then refractory behaviour.
        do_reset();
        cur_tab = '{8'd0, 8'd0, 8'd150, 8'd0};
        sweep(0, 0, 0, 0, 0);
        sweep(0, 0, 0, 0, 0);
        cur_tab = '{8'd0, 8'd0, 8'd250, 8'd0};
        sweep(0, 0, 0, 0, 0);
        sweep(0, 0, 0, 0, 0);
        sweep(0, 0, 0, 0, 0);

        // Spike held by a stalled consumer.
        do_reset();
        cur_tab = '{8'd0, 8'd0, 8'd150, 8'd0};
        sweep(0, 0, 0, 0, 0);
        sweep(5, 0, 0, 0, 0);

        // Threshold 255 with a write coincident with start; saturation; busy writes ignored.
        do_reset();
        cur_tab = '{8'd255, 8'd0, 8'd0, 8'd0};
        sweep(0, 0, 1, 1, 255);
        chk("thr_after_busy_write", dut.threshold, 255);
        cur_tab = '{8'd0, 8'd100, 8'd0, 8'd0};
        sweep(0, 0, 0, 0, 0);

        // Reset during the fetch of neuron 1.
        do_reset();
        cur_tab = '{8'd10, 8'd10, 8'd10, 8'd10};
        @(negedge clk);
        start = 1'b1;
        cur_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            if (cur_req && cur_idx == 2'd1) begin
                hit = 1;
                cur_valid = 1'b0;
                reset_n = 1'b0;
                #1;
                chk("midrst_busy", busy, 0);
                chk("midrst_cur_req", cur_req, 0);
                chk("midrst_done", done, 0);
                chk("midrst_step_count", step_count, 0);
                chk("midrst_mem0", dut.mem[0], 0);
            end else begin
                if (cur_req) current_in = cur_tab[cur_idx];
                @(negedge clk);
            end
        end
        chk("midrst_reached", hit, 1);
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        cur_valid = 1'b1;
        sweep(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
